// File: rtl/mem_bank_rw.sv
// mem_bank_rw: flip-flop based DEPTH x WIDTH storage with an addressed write port,
// a registered read port with write-first bypass, out-of-range address flagging
// and a sequenced bulk clear that walks every entry once.
module mem_bank_rw #(
   parameter int unsigned WIDTH = 35,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             wren,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] din,
   input  logic             rden,
   input  logic [AW-1:0]    raddr,
   input  logic             clr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             addr_err
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q;
   logic             dout_valid_q;
   logic             addr_err_q;

   logic             idle;
   logic             waddr_ok;
   logic             raddr_ok;
   logic             wr_go;
   logic             rd_go;
   logic [WIDTH-1:0] rd_data;

   // Port qualification: both ports are only live while not clearing.
   always_comb begin
      idle     = (state_q == StIdle);
      // Compare at 32 bits so a power-of-two DEPTH does not wrap to zero.
      waddr_ok = (32'(waddr) < DEPTH);
      raddr_ok = (32'(raddr) < DEPTH);
      wr_go    = idle && wren && waddr_ok;
      rd_go    = idle && rden;
      if (!raddr_ok) begin
         rd_data = '0;
      end else if (wr_go && (waddr == raddr)) begin
         rd_data = din;
      end else begin
         rd_data = mem_q[raddr];
      end
   end

   // FSM state and clear counter register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: a clear runs exactly DEPTH cycles, one entry per cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (clr) begin
               state_d = StClear;
            end
         end
         StClear: begin
            if (cnt_q == LastAddr) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == StClear);
   end

   // Storage: clear walk has priority; in IDLE a same-cycle clr still lets the write land.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (state_q == StClear) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_go) begin
         mem_q[waddr] <= din;
      end
   end

   // Registered read data, valid flag and address-error pulse.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         dout_valid_q <= rd_go;
         addr_err_q   <= idle && ((wren && !waddr_ok) || (rden && !raddr_ok));
         if (rd_go) begin
            dout_q <= rd_data;
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_bank_rw.sv
// Directed bench for mem_bank_rw: a DEPTH=8 instance and a DEPTH=6 instance share
// all inputs; each scenario task drives stimulus and checks outputs 1 ns after the edge.
module tb_mem_bank_rw;

   logic        clk;
   logic        arst_n;
   logic        wren;
   logic [2:0]  waddr;
   logic [34:0] din;
   logic        rden;
   logic [2:0]  raddr;
   logic        clr;

   logic [34:0] dout8, dout6;
   logic        dv8, dv6, busy8, busy6, aerr8, aerr6;

   int checks;
   int failures;

   logic [34:0] fill [8] = '{35'h0_1111_1111, 35'h1_2222_2222, 35'h2_3333_3333,
                             35'h3_4444_4444, 35'h4_5555_5555, 35'h5_6666_6666,
                             35'h6_7777_7777, 35'h7_0F0F_0F0F};

   mem_bank_rw #(.WIDTH(35), .DEPTH(8)) u_dut8 (
      .clk        (clk),
      .arst_n     (arst_n),
      .wren       (wren),
      .waddr      (waddr),
      .din        (din),
      .rden       (rden),
      .raddr      (raddr),
      .clr        (clr),
      .dout       (dout8),
      .dout_valid (dv8),
      .busy       (busy8),
      .addr_err   (aerr8)
   );

   mem_bank_rw #(.WIDTH(35), .DEPTH(6)) u_dut6 (
      .clk        (clk),
      .arst_n     (arst_n),
      .wren       (wren),
      .waddr      (waddr),
      .din        (din),
      .rden       (rden),
      .raddr      (raddr),
      .clr        (clr),
      .dout       (dout6),
      .dout_valid (dv6),
      .busy       (busy6),
      .addr_err   (aerr6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wren  = 1'b0;
      rden  = 1'b0;
      clr   = 1'b0;
      waddr = '0;
      raddr = '0;
      din   = '0;
   endtask

   task automatic write_all();
      for (int i = 0; i < 8; i++) begin
         wren  = 1'b1;
         waddr = 3'(i);
         din   = fill[i];
         tick();
      end
      wren = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      arst_n = 1'b0;
      #17;
      checks++;
      if (dout8 !== 35'h0 || dv8 !== 1'b0 || busy8 !== 1'b0 || aerr8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got dout=%h dv=%b busy=%b aerr=%b want 0/0/0/0",
                  dout8, dv8, busy8, aerr8);
      end
      arst_n = 1'b1;
      tick();
      for (int a = 0; a < 8; a++) begin
         rden  = 1'b1;
         raddr = 3'(a);
         tick();
         checks++;
         if (dout8 !== 35'h0 || dv8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_read[%0d] got dout=%h dv=%b want 0/1", a, dout8, dv8);
         end
      end
      rden = 1'b0;
      tick();
      checks++;
      if (dv8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_read_valid got %b want 0", dv8);
      end
   endtask

   task automatic test_write_read();
      wren  = 1'b1;
      waddr = 3'd3;
      din   = 35'h0_7F03_F80;
      tick();
      wren = 1'b0;
      checks++;
      if (dv8 !== 1'b0) begin
         failures++;
         $display("FAIL wr_only_valid got %b want 0", dv8);
      end
      rden  = 1'b1;
      raddr = 3'd3;
      tick();
      rden = 1'b0;
      checks++;
      if (dout8 !== 35'h0_7F03_F80 || dv8 !== 1'b1) begin
         failures++;
         $display("FAIL rd_addr3 got dout=%h dv=%b want 007f03f80/1", dout8, dv8);
      end
      tick();
      checks++;
      if (dout8 !== 35'h0_7F03_F80 || dv8 !== 1'b0) begin
         failures++;
         $display("FAIL rd_hold got dout=%h dv=%b want 007f03f80/0", dout8, dv8);
      end
   endtask

   task automatic test_write_first();
      wren  = 1'b1;
      waddr = 3'd5;
      din   = 35'h1_2345_6789;
      rden  = 1'b1;
      raddr = 3'd5;
      tick();
      wren = 1'b0;
      rden = 1'b0;
      checks++;
      if (dout8 !== 35'h1_2345_6789 || dv8 !== 1'b1) begin
         failures++;
         $display("FAIL write_first got dout=%h dv=%b want 123456789/1", dout8, dv8);
      end
      rden  = 1'b1;
      raddr = 3'd3;
      tick();
      rden = 1'b0;
      checks++;
      if (dout8 !== 35'h0_7F03_F80) begin
         failures++;
         $display("FAIL reread_addr3 got %h want 007f03f80", dout8);
      end
   endtask

   task automatic test_clear();
      int n;
      write_all();
      rden  = 1'b1;
      raddr = 3'd6;
      tick();
      rden = 1'b0;
      checks++;
      if (dout8 !== fill[6]) begin
         failures++;
         $display("FAIL fill_read6 got %h want %h", dout8, fill[6]);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (busy8 !== 1'b1) begin
         failures++;
         $display("FAIL clr_busy_rise got %b want 1", busy8);
      end
      n = 0;
      while (busy8 === 1'b1 && n < 20) begin
         wren  = 1'b1;
         waddr = 3'd2;
         din   = 35'h7_FFFF_FFFF;
         rden  = 1'b1;
         raddr = 3'd0;
         tick();
         n++;
         checks++;
         if (dv8 !== 1'b0 || aerr8 !== 1'b0) begin
            failures++;
            $display("FAIL clr_ignore_ports cyc=%0d got dv=%b aerr=%b want 0/0", n, dv8, aerr8);
         end
      end
      idle_inputs();
      checks++;
      if (n != 8) begin
         failures++;
         $display("FAIL clr_busy_len got %0d want 8", n);
      end
      checks++;
      if (dout8 !== fill[6]) begin
         failures++;
         $display("FAIL clr_dout_hold got %h want %h", dout8, fill[6]);
      end
      for (int a = 0; a < 8; a++) begin
         rden  = 1'b1;
         raddr = 3'(a);
         tick();
         checks++;
         if (dout8 !== 35'h0 || dv8 !== 1'b1) begin
            failures++;
            $display("FAIL clr_read[%0d] got dout=%h dv=%b want 0/1", a, dout8, dv8);
         end
      end
      rden = 1'b0;
      tick();
   endtask

   task automatic test_clr_with_access();
      int n;
      wren  = 1'b1;
      waddr = 3'd1;
      din   = 35'h2_ABCD_0123;
      rden  = 1'b1;
      raddr = 3'd1;
      clr   = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (dout8 !== 35'h2_ABCD_0123 || dv8 !== 1'b1 || busy8 !== 1'b1) begin
         failures++;
         $display("FAIL clr_same_cycle got dout=%h dv=%b busy=%b want 2abcd0123/1/1",
                  dout8, dv8, busy8);
      end
      n = 0;
      while (busy8 === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (busy8 !== 1'b0) begin
         failures++;
         $display("FAIL clr_same_cycle_timeout busy=%b want 0", busy8);
      end
      rden  = 1'b1;
      raddr = 3'd1;
      tick();
      rden = 1'b0;
      checks++;
      if (dout8 !== 35'h0) begin
         failures++;
         $display("FAIL clr_overwrites_write got %h want 0", dout8);
      end
   endtask

   task automatic test_out_of_range();
      write_all();
      wren  = 1'b1;
      waddr = 3'd7;
      din   = 35'h7_FFFF_FFFF;
      tick();
      wren = 1'b0;
      checks++;
      if (aerr6 !== 1'b1 || aerr8 !== 1'b0) begin
         failures++;
         $display("FAIL oor_write_err got d6=%b d8=%b want 1/0", aerr6, aerr8);
      end
      rden  = 1'b1;
      raddr = 3'd0;
      tick();
      checks++;
      if (dout6 !== fill[0] || aerr6 !== 1'b0) begin
         failures++;
         $display("FAIL oor_pre_read got dout=%h aerr=%b want %h/0", dout6, aerr6, fill[0]);
      end
      raddr = 3'd7;
      tick();
      rden = 1'b0;
      checks++;
      if (dout6 !== 35'h0 || dv6 !== 1'b1 || aerr6 !== 1'b1) begin
         failures++;
         $display("FAIL oor_read got dout=%h dv=%b aerr=%b want 0/1/1", dout6, dv6, aerr6);
      end
      checks++;
      if (dout8 !== 35'h7_FFFF_FFFF || aerr8 !== 1'b0) begin
         failures++;
         $display("FAIL inrange8_read7 got dout=%h aerr=%b want 7ffffffff/0", dout8, aerr8);
      end
      tick();
      checks++;
      if (aerr6 !== 1'b0) begin
         failures++;
         $display("FAIL oor_err_pulse got %b want 0", aerr6);
      end
      for (int a = 0; a < 6; a++) begin
         rden  = 1'b1;
         raddr = 3'(a);
         tick();
         checks++;
         if (dout6 !== fill[a]) begin
            failures++;
            $display("FAIL oor_intact[%0d] got %h want %h", a, dout6, fill[a]);
         end
      end
      rden = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_clear();
      write_all();
      rden  = 1'b1;
      raddr = 3'd5;
      tick();
      rden = 1'b0;
      checks++;
      if (dout8 !== fill[5]) begin
         failures++;
         $display("FAIL mid_pre_read got %h want %h", dout8, fill[5]);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      tick();
      #2;
      arst_n = 1'b0;
      #1;
      checks++;
      if (busy8 !== 1'b0 || dout8 !== 35'h0 || dv8 !== 1'b0) begin
         failures++;
         $display("FAIL mid_async_reset got busy=%b dout=%h dv=%b want 0/0/0", busy8, dout8, dv8);
      end
      #2;
      arst_n = 1'b1;
      tick();
      for (int a = 0; a < 8; a++) begin
         rden  = 1'b1;
         raddr = 3'(a);
         tick();
         checks++;
         if (dout8 !== 35'h0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_read[%0d] got dout=%h busy=%b want 0/0", a, dout8, busy8);
         end
      end
      wren  = 1'b1;
      waddr = 3'd4;
      din   = 35'h5_0A0A_5A5A;
      rden  = 1'b0;
      tick();
      wren  = 1'b0;
      rden  = 1'b1;
      raddr = 3'd4;
      tick();
      rden = 1'b0;
      checks++;
      if (dout8 !== 35'h5_0A0A_5A5A || dv8 !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_rw got dout=%h dv=%b want 50a0a5a5a/1", dout8, dv8);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      arst_n   = 1'b0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_write_first();
      test_clear();
      test_clr_with_access();
      test_out_of_range();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
